// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared types for the decode-stage operand hazard controller.
//   fwd_sel_e      : operand source select (regfile / EX / MEM / WB result)
//   hazard_entry_t : one in-flight destination record {valid, rd, we, is_load}
//   entry_match    : does an in-flight entry produce the value a source reads
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  is_load;
    } hazard_entry_t;

    // x0 is hard-wired to zero, so it is never a forwarding target.
    function automatic logic entry_match(
        input hazard_entry_t         e,
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  rs_used
    );
        return e.valid && e.we && rs_used && (rs != '0) && (e.rd == rs);
    endfunction

endpackage

// File: rtl/operand_hazard_ctrl_fwd_match.sv
// ---------------------------------------------------------------------------
// fwd_match
// Combinational priority match of one source operand against the EX, MEM
// and WB in-flight entries. The youngest producer wins.
// Ports:
//   rs, rs_used                 : source register index and whether it is read
//   ex_entry/mem_entry/wb_entry : tracked in-flight destinations
//   fwd_sel                     : selected operand source
//   prod_is_load                : the selected producer is a load
// ---------------------------------------------------------------------------
module fwd_match
    import core_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  rs_used,
    input  hazard_entry_t         ex_entry,
    input  hazard_entry_t         mem_entry,
    input  hazard_entry_t         wb_entry,
    output fwd_sel_e              fwd_sel,
    output logic                  prod_is_load
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    always_comb begin
        ex_hit  = entry_match(ex_entry, rs, rs_used);
        mem_hit = entry_match(mem_entry, rs, rs_used);
        wb_hit  = entry_match(wb_entry, rs, rs_used);

        fwd_sel      = FWD_RF;
        prod_is_load = 1'b0;
        if (ex_hit) begin
            fwd_sel      = FWD_EX;
            prod_is_load = ex_entry.is_load;
        end else if (mem_hit) begin
            fwd_sel      = FWD_MEM;
            prod_is_load = mem_entry.is_load;
        end else if (wb_hit) begin
            fwd_sel      = FWD_WB;
            prod_is_load = wb_entry.is_load;
        end
    end

endmodule

// File: rtl/operand_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// operand_hazard_ctrl
// Decode-stage controller for the ALU operand path. Tracks the destination
// registers of the instructions in EX, MEM and WB, generates forwarding
// selects for operands A and B, and stalls decode for one cycle on a
// load-use hazard while a bubble is injected into EX.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   id_*                  : decode-stage instruction fields
//   pipe_advance          : downstream accepts; tracking entries shift
//   flush                 : kill the decode instruction and the EX entry
//   fwd_a_sel, fwd_b_sel  : operand source selects (00 RF, 01 EX, 10 MEM, 11 WB)
//   id_stall              : decode must hold because of a load-use hazard
//   id_issue              : decode instruction enters EX on this edge
//   stall_count           : saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module operand_hazard_ctrl
    import core_pkg::*;
#(
    parameter int REG_ADDR_W  = core_pkg::REG_ADDR_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic [REG_ADDR_W-1:0]  id_rd,
    input  logic                   id_rd_we,
    input  logic                   id_is_load,
    input  logic                   pipe_advance,
    input  logic                   flush,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic                   id_stall,
    output logic                   id_issue,
    output logic [STALL_CNT_W-1:0] stall_count
);

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(
        input logic [STALL_CNT_W-1:0] v
    );
        if (&v) begin
            return v;
        end
        return v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    hazard_entry_t ex_p0;
    hazard_entry_t mem_p1;
    hazard_entry_t wb_p2;
    hazard_entry_t id_entry;

    fwd_sel_e fwd_a;
    fwd_sel_e fwd_b;
    logic     a_prod_load;
    logic     b_prod_load;
    logic     load_use;

    fwd_match u_fwd_a (
        .rs           (id_rs1),
        .rs_used      (id_rs1_used),
        .ex_entry     (ex_p0),
        .mem_entry    (mem_p1),
        .wb_entry     (wb_p2),
        .fwd_sel      (fwd_a),
        .prod_is_load (a_prod_load)
    );

    fwd_match u_fwd_b (
        .rs           (id_rs2),
        .rs_used      (id_rs2_used),
        .ex_entry     (ex_p0),
        .mem_entry    (mem_p1),
        .wb_entry     (wb_p2),
        .fwd_sel      (fwd_b),
        .prod_is_load (b_prod_load)
    );

    assign fwd_a_sel = fwd_a;
    assign fwd_b_sel = fwd_b;

    // Only a load sitting in EX is a hazard: its data exists one stage later,
    // so a match that resolves to MEM or WB forwards normally. An EX match
    // always has priority, so "selected EX and producer is a load" is exactly
    // "EX matches and EX is a load".
    always_comb begin
        load_use = id_valid &&
                   (((fwd_a == FWD_EX) && a_prod_load) ||
                    ((fwd_b == FWD_EX) && b_prod_load));
        id_stall = load_use && !flush;
        id_issue = id_valid && !id_stall && !flush && pipe_advance;

        id_entry.valid   = 1'b1;
        id_entry.rd      = id_rd;
        id_entry.we      = id_rd_we;
        id_entry.is_load = id_is_load;
    end

    // Decode -> EX (p0) -> MEM (p1) -> WB (p2) tracking shift
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_p0       <= '0;
            mem_p1      <= '0;
            wb_p2       <= '0;
            stall_count <= '0;
        end else begin
            if (pipe_advance) begin
                wb_p2  <= mem_p1;
                // A flushed EX instruction must not reach MEM.
                mem_p1 <= flush ? hazard_entry_t'('0) : ex_p0;
                ex_p0  <= id_issue ? id_entry : hazard_entry_t'('0);
            end else if (flush) begin
                ex_p0.valid <= 1'b0;
            end

            if (id_stall) begin
                stall_count <= sat_inc(stall_count);
            end
        end
    end

endmodule

// File: tb/tb_operand_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_operand_hazard_ctrl
// Directed bench for operand_hazard_ctrl: reset, EX forwarding, priority,
// x0, load-use stall, flush, backpressure and counter saturation.
// ---------------------------------------------------------------------------
module tb_operand_hazard_ctrl;

    localparam int RW = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [RW-1:0] id_rs1;
    logic [RW-1:0] id_rs2;
    logic          id_rs1_used;
    logic          id_rs2_used;
    logic [RW-1:0] id_rd;
    logic          id_rd_we;
    logic          id_is_load;
    logic          pipe_advance;
    logic          flush;
    logic [1:0]    fwd_a_sel;
    logic [1:0]    fwd_b_sel;
    logic          id_stall;
    logic          id_issue;
    logic [CW-1:0] stall_count;

    int total = 0;
    int bad   = 0;
    logic [CW-1:0] exp_cnt;

    operand_hazard_ctrl #(.REG_ADDR_W(RW), .STALL_CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_rd_we     (id_rd_we),
        .id_is_load   (id_is_load),
        .pipe_advance (pipe_advance),
        .flush        (flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .id_stall     (id_stall),
        .id_issue     (id_issue),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                         input logic u1, input logic u2, input logic [RW-1:0] rd,
                         input logic we, input logic ld);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rs1_used = u1;
        id_rs2_used = u2;
        id_rd       = rd;
        id_rd_we    = we;
        id_is_load  = ld;
        #1;
    endtask

    // Empty the tracking pipeline with bubbles.
    task automatic drain();
        flush        = 1'b0;
        pipe_advance = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        flush        = 1'b0;
        pipe_advance = 1'b1;
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        drive(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
        total++;
        if (stall_count !== 16'd0) begin
            bad++; $display("FAIL reset_count got=%0d want=0", stall_count);
        end
        total++;
        if ({fwd_a_sel, fwd_b_sel, id_stall, id_issue} !== 6'b0) begin
            bad++; $display("FAIL reset_outputs got=%b want=000000",
                            {fwd_a_sel, fwd_b_sel, id_stall, id_issue});
        end
        // rd=5 was presented during reset but must not have been recorded.
        pipe_advance = 1'b0;
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
        total++;
        if (fwd_a_sel !== 2'b00) begin
            bad++; $display("FAIL reset_entries fwd_a got=%b want=00", fwd_a_sel);
        end
        exp_cnt = '0;
    endtask

    task automatic test_ex_forward();
        drain();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        total++;
        if (id_issue !== 1'b1) begin
            bad++; $display("FAIL exfwd_issue got=%b want=1", id_issue);
        end
        tick();
        drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        total++;
        if ({fwd_a_sel, fwd_b_sel, id_stall} !== 5'b01010) begin
            bad++; $display("FAIL exfwd_ab got=%b want=01010", {fwd_a_sel, fwd_b_sel, id_stall});
        end
        drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
        total++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0100) begin
            bad++; $display("FAIL exfwd_imm got=%b want=0100", {fwd_a_sel, fwd_b_sel});
        end
    endtask

    task automatic test_priority();
        drain();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
        repeat (3) tick();
        pipe_advance = 1'b0;
        drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0);
        total++;
        if (fwd_a_sel !== 2'b01) begin
            bad++; $display("FAIL prio_ex got=%b want=01", fwd_a_sel);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        total++;
        if (fwd_a_sel !== 2'b10) begin
            bad++; $display("FAIL prio_mem got=%b want=10", fwd_a_sel);
        end
        pipe_advance = 1'b1;
        drive(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0);
        tick();
        pipe_advance = 1'b0;
        drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0);
        total++;
        if (fwd_a_sel !== 2'b11) begin
            bad++; $display("FAIL prio_wb got=%b want=11", fwd_a_sel);
        end
    endtask

    task automatic test_x0();
        drain();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);
        total++;
        if ({fwd_a_sel, fwd_b_sel, id_stall, id_issue} !== 6'b000001) begin
            bad++; $display("FAIL x0 got=%b want=000001",
                            {fwd_a_sel, fwd_b_sel, id_stall, id_issue});
        end
    endtask

    task automatic test_load_use();
        drain();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd1, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        total++;
        if ({id_stall, id_issue, fwd_b_sel} !== 4'b1001) begin
            bad++; $display("FAIL lu_stall got=%b want=1001", {id_stall, id_issue, fwd_b_sel});
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        total++;
        if ({id_stall, id_issue, fwd_b_sel} !== 4'b0110) begin
            bad++; $display("FAIL lu_release got=%b want=0110", {id_stall, id_issue, fwd_b_sel});
        end
        total++;
        if (stall_count !== exp_cnt) begin
            bad++; $display("FAIL lu_count got=%0d want=%0d", stall_count, exp_cnt);
        end
        tick();
        drive(1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        total++;
        if (fwd_a_sel !== 2'b01) begin
            bad++; $display("FAIL lu_consumer_in_ex got=%b want=01", fwd_a_sel);
        end
    endtask

    task automatic test_flush_hazard();
        drain();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
        tick();
        flush = 1'b1;
        drive(1'b1, 5'd1, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        total++;
        if ({id_stall, id_issue} !== 2'b00) begin
            bad++; $display("FAIL flush_hz got=%b want=00", {id_stall, id_issue});
        end
        tick();
        flush = 1'b0;
        #1;
        total++;
        if ({fwd_b_sel, id_stall, id_issue} !== 4'b0001) begin
            bad++; $display("FAIL flush_cleared got=%b want=0001", {fwd_b_sel, id_stall, id_issue});
        end
        total++;
        if (stall_count !== exp_cnt) begin
            bad++; $display("FAIL flush_count got=%0d want=%0d", stall_count, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        drain();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0);
        tick();
        pipe_advance = 1'b0;
        drive(1'b1, 5'd11, 5'd10, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({fwd_a_sel, fwd_b_sel, id_stall, id_issue} !== 6'b101100) begin
                bad++; $display("FAIL bp_hold%0d got=%b want=101100", i,
                                {fwd_a_sel, fwd_b_sel, id_stall, id_issue});
            end
            tick();
        end
        drive(1'b1, 5'd12, 5'd10, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        total++;
        if (fwd_a_sel !== 2'b01) begin
            bad++; $display("FAIL bp_ex_held got=%b want=01", fwd_a_sel);
        end
        pipe_advance = 1'b1;
        #1;
        total++;
        if (id_issue !== 1'b1) begin
            bad++; $display("FAIL bp_resume got=%b want=1", id_issue);
        end
    endtask

    task automatic test_saturation();
        drain();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        // Load held in EX by backpressure: the consumer stalls every cycle.
        pipe_advance = 1'b0;
        drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
        total++;
        if (id_stall !== 1'b1) begin
            bad++; $display("FAIL sat_stall got=%b want=1", id_stall);
        end
        repeat (int'(16'hFFFE - exp_cnt)) tick();
        total++;
        if (stall_count !== 16'hFFFE) begin
            bad++; $display("FAIL sat_near got=%h want=fffe", stall_count);
        end
        repeat (3) tick();
        total++;
        if (stall_count !== 16'hFFFF) begin
            bad++; $display("FAIL sat_hold got=%h want=ffff", stall_count);
        end
        // Reset in the middle of the stall.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total++;
        if ({id_stall, stall_count} !== {1'b0, 16'h0000}) begin
            bad++; $display("FAIL reset_mid_stall got=%b/%h want=0/0000", id_stall, stall_count);
        end
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_priority();
        test_x0();
        test_load_use();
        test_flush_hazard();
        test_backpressure();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
